// File: rtl/request_unit.sv
// request_unit
//   Sequences the memory accesses of a single-cycle datapath on behalf of the
//   decoder. It fetches an instruction, then performs the data access the
//   instruction asks for, if any. It strobes pc_en once for each completed
//   instruction and latches HALT.
//
//   Optional feature macro: REQ_PERF_EN. When defined, it enables the
//   instr_cnt/stall_cnt performance counters. When undefined, both ports are
//   tied to zero and no counter flops exist.
//
//   Parameters
//     TIMEOUT   max wait cycles for ihit/dhit before a fault; 0 removes the watchdog
//   Ports
//     CLK, RST              clock; synchronous active-high reset
//     ihit, dhit            instruction / data memory completion
//     cu_dREN, cu_dWEN      decoder load / store request
//     cu_halt               decoder HALT
//     imemREN               instruction read request (registered-state decode)
//     dmemREN, dmemWEN      data read / write request (registered-state decode)
//     pc_en                 PC advance strobe, combinational on the hit cycle
//     halt, timeout         sticky halted / watchdog fault
//     instr_cnt, stall_cnt  retired instructions / memory wait cycles
//
//   state  | meaning
//   IDLE   | one cycle after reset, all outputs low
//   FETCH  | imemREN high, waiting for ihit
//   DATA   | latched load or store in flight, waiting for dhit
//   HALTED | halt high, only RST leaves
module request_unit #(
  parameter int TIMEOUT = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        cu_dREN,
  input  logic        cu_dWEN,
  input  logic        cu_halt,
  output logic        imemREN,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic        pc_en,
  output logic        halt,
  output logic        timeout,
  output logic [31:0] instr_cnt,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, HALTED} state_t;

  state_t state_q, state_d;
  logic   load_q, load_d;
  logic   store_q, store_d;
  logic   halt_q, halt_d;
  logic   timeout_q, timeout_d;
  logic   waiting;
  logic   wd_fault;

  // A cycle spent in FETCH or DATA without the hit that state is waiting for.
  assign waiting = ((state_q == FETCH) && !ihit) || ((state_q == DATA) && !dhit);

  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam int WW = $clog2(TIMEOUT + 1);
      localparam logic [WW-1:0] LIMIT = WW'(TIMEOUT - 1);

      logic [WW-1:0] wait_q, wait_d;

      // The state only changes on an accepted hit or on a fault, so both
      // clear conditions collapse into "not waiting, or faulting now".
      always_comb begin
        wait_d = '0;
        if (waiting && (wait_q != LIMIT)) wait_d = wait_q + WW'(1);
      end

      always_ff @(posedge CLK) begin
        if (RST) wait_q <= '0;
        else     wait_q <= wait_d;
      end

      // Fires on the TIMEOUT-th consecutive wait cycle.
      assign wd_fault = waiting && (wait_q == LIMIT);
    end else begin : g_no_wd
      assign wd_fault = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    load_d    = load_q;
    store_d   = store_q;
    halt_d    = halt_q;
    timeout_d = timeout_q;
    pc_en     = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (ihit) begin
          if (cu_halt) begin
            state_d = HALTED;
          end else if (cu_dWEN || cu_dREN) begin
            state_d = DATA;
            store_d = cu_dWEN;
            load_d  = cu_dREN && !cu_dWEN;
          end else begin
            pc_en = 1'b1;
          end
        end else if (wd_fault) begin
          state_d   = HALTED;
          timeout_d = 1'b1;
        end
      end
      DATA: begin
        if (dhit) begin
          pc_en   = 1'b1;
          state_d = FETCH;
        end else if (wd_fault) begin
          state_d   = HALTED;
          timeout_d = 1'b1;
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
    if (state_d == HALTED) halt_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      load_q    <= 1'b0;
      store_q   <= 1'b0;
      halt_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      load_q    <= load_d;
      store_q   <= store_d;
      halt_q    <= halt_d;
      timeout_q <= timeout_d;
    end
  end

  assign imemREN = (state_q == FETCH);
  assign dmemREN = (state_q == DATA) && load_q;
  assign dmemWEN = (state_q == DATA) && store_q;
  assign halt    = halt_q;
  assign timeout = timeout_q;

`ifdef REQ_PERF_EN
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // pc_en and waiting are both low in HALTED, which keeps the counters frozen there.
  always_comb begin
    instr_cnt_d = instr_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (pc_en && (instr_cnt_q != 32'hFFFF_FFFF))   instr_cnt_d = instr_cnt_q + 32'd1;
    if (waiting && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      instr_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign instr_cnt = instr_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign instr_cnt = 32'h0;
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_request_unit.sv
// Testbench for request_unit with TIMEOUT=4.
// Each stimulus cycle pushes the expected outputs for that cycle into a queue,
// and a monitor on the falling edge pops each entry and compares it.
module tb_request_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ihit = 1'b0, dhit = 1'b0;
  logic        cu_dREN = 1'b0, cu_dWEN = 1'b0, cu_halt = 1'b0;
  logic        imemREN, dmemREN, dmemWEN, pc_en, halt, timeout;
  logic [31:0] instr_cnt, stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       nm;
    logic [5:0]  o;     // {imemREN, dmemREN, dmemWEN, pc_en, halt, timeout}
    bit          chk;
    logic [31:0] ei;
    logic [31:0] es;
  } exp_t;

  exp_t q[$];
  exp_t e;

  request_unit #(.TIMEOUT(4)) u_dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .cu_dREN(cu_dREN), .cu_dWEN(cu_dWEN), .cu_halt(cu_halt),
    .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .pc_en(pc_en), .halt(halt), .timeout(timeout),
    .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] pf(input logic [31:0] v);
`ifdef REQ_PERF_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  // One clock cycle: drive this cycle's inputs and queue this cycle's outputs.
  task automatic cyc(input bit rst, input bit ih, input bit dh, input bit rn,
                     input bit wn, input bit hl, input logic [5:0] o,
                     input string nm, input bit chk = 1'b0,
                     input logic [31:0] ei = 32'd0, input logic [31:0] es = 32'd0);
    exp_t x;
    @(posedge CLK);
    #1;
    RST = rst; ihit = ih; dhit = dh; cu_dREN = rn; cu_dWEN = wn; cu_halt = hl;
    x.nm = nm; x.o = o; x.chk = chk; x.ei = ei; x.es = es;
    q.push_back(x);
  endtask

  always @(negedge CLK) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      n_cmp++;
      if ({imemREN, dmemREN, dmemWEN, pc_en, halt, timeout} !== e.o) begin
        n_bad++;
        $display("FAIL %s: outputs {imem,dren,dwen,pc_en,halt,to} got %b want %b at %0t",
                 e.nm, {imemREN, dmemREN, dmemWEN, pc_en, halt, timeout}, e.o, $time);
      end
      if (e.chk) begin
        n_cmp++;
        if (instr_cnt !== e.ei) begin
          n_bad++;
          $display("FAIL %s_instr_cnt: got %0d want %0d", e.nm, instr_cnt, e.ei);
        end
        n_cmp++;
        if (stall_cnt !== e.es) begin
          n_bad++;
          $display("FAIL %s_stall_cnt: got %0d want %0d", e.nm, stall_cnt, e.es);
        end
      end
    end
  end

  initial begin
    // Reset for two cycles, ihit high, ADDU on the decoder.
    cyc(1, 1, 0, 0, 0, 0, 6'b000000, "rst_1");
    cyc(1, 1, 0, 0, 0, 0, 6'b000000, "rst_2", 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 6'b000000, "post_rst_idle");
    cyc(0, 1, 0, 0, 0, 0, 6'b100100, "addu_first", 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 6'b100100, "addu");
    cyc(0, 1, 0, 0, 0, 0, 6'b100100, "addu_5", 1, pf(4), 0);

    // LW: dhit on the third DATA cycle; ihit and decoder changes in DATA are ignored.
    cyc(0, 1, 0, 1, 0, 0, 6'b100000, "lw_fetch", 1, pf(5), 0);
    cyc(0, 1, 0, 0, 0, 0, 6'b010000, "lw_wait1");
    cyc(0, 1, 0, 0, 1, 0, 6'b010000, "lw_wait2_dec_ign");
    cyc(0, 1, 1, 0, 0, 0, 6'b010100, "lw_dhit", 1, pf(5), pf(2));
    cyc(0, 1, 0, 0, 0, 0, 6'b100100, "lw_refetch", 1, pf(6), pf(2));

    // FETCH waits; dhit in FETCH is ignored.
    cyc(0, 0, 0, 0, 0, 0, 6'b100000, "fetch_wait");
    cyc(0, 0, 1, 0, 0, 0, 6'b100000, "fetch_dhit_ign");
    cyc(0, 1, 0, 0, 0, 0, 6'b100100, "fetch_hit", 1, pf(7), pf(4));

    // dREN and dWEN both set: the store wins.
    cyc(0, 1, 0, 1, 1, 0, 6'b100000, "both_fetch");
    cyc(0, 0, 1, 0, 0, 0, 6'b001100, "both_store");
    cyc(0, 1, 0, 0, 0, 0, 6'b100100, "after_sw", 1, pf(9), pf(4));

    // HALT with a store: halt has priority, and HALTED holds while inputs toggle.
    cyc(0, 1, 0, 0, 1, 1, 6'b100000, "halt_fetch");
    for (int i = 0; i < 20; i++) begin
      logic [1:0] b;
      b = i[1:0];
      cyc(0, b[0], ~b[0], b[1], b[0], 1, 6'b000010, "halted", 1, pf(10), pf(4));
    end

    // Watchdog in FETCH: four wait cycles, then a fault.
    cyc(1, 0, 0, 0, 0, 0, 6'b000010, "rst_from_halt");
    cyc(0, 0, 0, 0, 0, 0, 6'b000000, "idle2", 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 6'b100000, "wd_fetch_wait");
    cyc(0, 1, 0, 0, 0, 0, 6'b000011, "wd_fetch_fault");
    cyc(0, 1, 1, 0, 0, 0, 6'b000011, "wd_fetch_hold", 1, 0, pf(4));

    // Reset during DATA clears the fault and restarts from IDLE.
    cyc(1, 0, 0, 0, 0, 0, 6'b000011, "rst_from_fault");
    cyc(0, 1, 0, 0, 0, 0, 6'b000000, "idle3");
    cyc(0, 1, 0, 1, 0, 0, 6'b100000, "lw2_fetch");
    cyc(0, 0, 0, 0, 0, 0, 6'b010000, "lw2_wait");
    cyc(1, 0, 0, 0, 0, 0, 6'b010000, "rst_mid_data");
    cyc(0, 1, 0, 0, 0, 0, 6'b000000, "idle4");
    cyc(0, 1, 0, 0, 0, 0, 6'b100100, "addu_after_rst");

    // Three wait cycles followed by a hit must not fault.
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 6'b100000, "wait3");
    cyc(0, 1, 0, 0, 0, 0, 6'b100100, "no_fault_3wait");

    // Watchdog in DATA.
    cyc(0, 1, 0, 0, 1, 0, 6'b100000, "sw_fetch");
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 6'b001000, "wd_data_wait");
    cyc(0, 0, 1, 0, 0, 0, 6'b000011, "wd_data_fault");

    // Ten one-cycle instructions after a reset.
    cyc(1, 0, 0, 0, 0, 0, 6'b000011, "rst_final");
    cyc(0, 1, 0, 0, 0, 0, 6'b000000, "idle5");
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0, 0, 6'b100100, "addu10");
    cyc(0, 0, 0, 0, 0, 0, 6'b100000, "count10", 1, pf(10), 0);

    @(posedge CLK);
    @(negedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
